plane_pwm_driver: RTL and testbench
===================================

Name: plane_pwm_driver

Overview:
Next-generation LED-cube plane driver. Receives byte-wide commands and brightness data from the host MCU over a strobe bus, stores per-channel brightness in a double-buffered frame memory, and drives OUT_NUM PWM outputs. Channel count, brightness depth and PWM rate are parametrised. Frame swaps are tear-free and occur only at PWM period boundaries.

Parameters:
OUT_NUM, 64, number of PWM channels; 2..128.
D_WIDTH, 8, host data bus width; must be >= 8 and >= C_WIDTH.
C_WIDTH, 5, brightness/PWM counter width; period = 2^C_WIDTH ticks.
A_WIDTH, 6, channel address width; must be <= 7 and 2^A_WIDTH >= OUT_NUM.
PRESC, 1, clk cycles per PWM tick; >= 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
dataIn  in  D_WIDTH  host command/data byte
dataEn  in  1  host strobe; its falling edge performs the transaction
rs  in  1  1 = command, 0 = brightness data
pwmOut  out  OUT_NUM  registered PWM outputs
frameSync  out  1  one-cycle pulse on each completed bank swap
swapPending  out  1  swap requested but not yet performed
cmdErr  out  1  one-cycle pulse on an illegal command or address

Behaviour:
- Reset (async assert, sync release): pwmOut=0, frameSync=0, swapPending=0, cmdErr=0. Both banks are all zero. addr=0, incDec=0 (decrement), pwmEnabled=0, bank select sel=0, cnt=0, prescaler=0.
- Host input:
  - dataEn passes through a 2-flop synchroniser, then a delay flop; fall = delayed & ~synced.
  - dataIn and rs are sampled in the fall cycle. The host holds them stable for >= 3 clk after driving dataEn low.
  - Effect is visible after the 3rd rising edge that samples dataEn low.
- Banks: two banks of OUT_NUM x C_WIDTH. Active bank = sel; shadow bank = ~sel. Host writes go only to the shadow bank; PWM reads only the active bank.
- Data (rs=0): shadow[addr] <= dataIn[C_WIDTH-1:0]; upper bits are ignored.
  - incDec=1: addr steps +1, wrapping OUT_NUM-1 -> 0.
  - incDec=0: addr steps -1, wrapping 0 -> OUT_NUM-1.
- Commands (rs=1, decoded on dataIn[7:0]):
  - 0x01: clear the whole shadow bank in one cycle.
  - 0x02: addr <= 0.
  - 0x04/0x05: incDec <= dataIn[0].
  - 0x08/0x09: pwmEnabled <= dataIn[0].
  - 0x10: swapPending <= 1. A repeat while pending has no further effect.
  - 0x11: cancel a pending swap; swapPending <= 0.
  - 1xxx_xxxx: addr <= dataIn[A_WIDTH-1:0]. If dataIn[6:0] >= OUT_NUM: addr is unchanged and cmdErr pulses.
  - Any other value: no state change; cmdErr pulses.
- PWM timing:
  - The prescaler counts 0..PRESC-1; tick is asserted when it equals PRESC-1.
  - cnt increments on each tick and wraps from 2^C_WIDTH-1 to 0.
- PWM output: pwmOut[i] <= pwmEnabled & (active[i] > cnt), registered with 1-clk latency.
  - Value 0 gives always off; the maximum value gives (2^C-1)/2^C duty.
  - pwmEnabled=0 forces all outputs to 0 from the next edge.
  - The counter keeps running while PWM is disabled.
- Swap: on a tick with cnt == 2^C_WIDTH-1 and swapPending=1, at the same edge:
  - sel toggles, cnt -> 0, swapPending -> 0, frameSync = 1 for one cycle.
  - The shadow is not copied; the new shadow holds the frame that was active two swaps ago.
- Simultaneous events:
  - A write or clear in the swap cycle targets the shadow as defined by sel before that edge, so it lands in the newly active bank.
  - A 0x10 command in the swap cycle: the swap proceeds and swapPending ends the cycle at 1 (new request).
  - A 0x11 command in the swap cycle: the swap proceeds and swapPending = 0.
- A reset assertion mid-transaction aborts it immediately; any half-seen strobe is discarded.

Test Plan:
1. Reset, send cmd 0x05, 0x02, then data 31,16,0 -> shadow[0..2]=31,16,0, addr=3, no pwmOut activity (disabled).
2. After test 1, cmd 0x10, 0x09 -> frameSync pulses at the first cnt wrap; then per 32-clk period ch0 is high 31 clk, ch1 high 16 clk, ch2 never high; swapPending=0.
3. Writes while active: send data 5 to addr 0 without a swap -> ch0 duty stays 31/32. Then cmd 0x10 -> duty changes to 5/32 exactly at the next period start, with no partial period.
4. Wrap: OUT_NUM=64, cmd 0x04, addr=0, write 7 -> shadow[0]=7, addr=63. Cmd 0xC0 (addr 64, OUT_NUM=48 build) -> cmdErr pulse, addr unchanged.
5. Collision: time 0x10 so the swap lands in the same cycle as a data write to addr 4 -> the value appears in the active bank; the new shadow bank is unchanged.
6. Reset asserted mid-period with outputs high -> pwmOut=0 asynchronously, banks cleared; cmd 0x03 after reset -> cmdErr pulse.

Source files
------------

// File: rtl/plane_pwm_driver_if.sv
// plane_pwm_driver_if: host strobe bus plus PWM/status outputs of the plane driver
interface plane_pwm_driver_if #(
  parameter int OUT_NUM = 64,
  parameter int D_WIDTH = 8
);
  logic [D_WIDTH-1:0] dataIn;
  logic               dataEn;
  logic               rs;
  logic [OUT_NUM-1:0] pwmOut;
  logic               frameSync;
  logic               swapPending;
  logic               cmdErr;
  modport master (output dataIn, dataEn, rs, input pwmOut, frameSync, swapPending, cmdErr);
  modport slave  (input dataIn, dataEn, rs, output pwmOut, frameSync, swapPending, cmdErr);
endinterface

// File: rtl/plane_pwm_driver.sv
// plane_pwm_driver: strobe-bus host interface, double-buffered brightness banks, tear-free PWM
module plane_pwm_driver #(
  parameter int OUT_NUM = 64,
  parameter int D_WIDTH = 8,
  parameter int C_WIDTH = 5,
  parameter int A_WIDTH = 6,
  parameter int PRESC   = 1
) (
  input logic             clk,
  input logic             reset,
  plane_pwm_driver_if.slave bus
);
  localparam int PW = PRESC > 1 ? $clog2(PRESC) : 1;
  localparam logic [C_WIDTH-1:0] CMAX  = '1;
  localparam logic [A_WIDTH-1:0] ALAST = A_WIDTH'(OUT_NUM - 1);
  logic                en_s1_q, en_s2_q, en_dl_q;
  logic                fall, is_cmd, is_dat;
  logic [7:0]          cmd;
  logic                c_clr, c_home, c_dir, c_en, c_swp, c_cnl, c_adr, adr_ok, bad;
  logic [PW-1:0]       pre_q;
  logic                tick, swap;
  logic [C_WIDTH-1:0]  cnt_q;
  logic                sel_q;
  logic                pend_q, pend_d;
  logic [A_WIDTH-1:0]  addr_q, addr_d;
  logic                inc_q, inc_d, pen_q, pen_d;
  logic [C_WIDTH-1:0]  bank_q [2][OUT_NUM];
  logic [OUT_NUM-1:0]  pwm_q, pwm_d;
  logic                fs_q, err_q;
  assign fall   = en_dl_q & ~en_s2_q;
  assign is_cmd = fall & bus.rs;
  assign is_dat = fall & ~bus.rs;
  assign cmd    = bus.dataIn[7:0];
  assign c_clr  = cmd == 8'h01;
  assign c_home = cmd == 8'h02;
  assign c_dir  = cmd[7:1] == 7'h02;
  assign c_en   = cmd[7:1] == 7'h04;
  assign c_swp  = cmd == 8'h10;
  assign c_cnl  = cmd == 8'h11;
  assign c_adr  = cmd[7];
  assign adr_ok = 32'(cmd[6:0]) < OUT_NUM;
  assign bad    = c_adr ? ~adr_ok : ~(c_clr | c_home | c_dir | c_en | c_swp | c_cnl);
  assign tick   = pre_q == PW'(PRESC - 1);
  assign swap   = tick & (cnt_q == CMAX) & pend_q;
  // next-state for address pointer, direction, enable and swap request
  always_comb begin
    addr_d = is_dat ? (inc_q ? (addr_q == ALAST ? '0 : addr_q + A_WIDTH'(1))
                             : (addr_q == '0 ? ALAST : addr_q - A_WIDTH'(1))) : addr_q;
    if (is_cmd & c_home) addr_d = '0;
    if (is_cmd & c_adr & adr_ok) addr_d = cmd[A_WIDTH-1:0];
    inc_d  = (is_cmd & c_dir) ? cmd[0] : inc_q;
    pen_d  = (is_cmd & c_en) ? cmd[0] : pen_q;
    pend_d = (is_cmd & c_swp) ? 1'b1 : (is_cmd & c_cnl) ? 1'b0 : swap ? 1'b0 : pend_q;
  end
  // compare every active-bank channel against the running period counter
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < OUT_NUM; i++) pwm_d[i] = pen_q & (bank_q[sel_q][i] > cnt_q);
  end
  // strobe synchroniser, PWM timebase, control state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_s1_q <= 1'b0;
      en_s2_q <= 1'b0;
      en_dl_q <= 1'b0;
      pre_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      inc_q   <= 1'b0;
      pen_q   <= 1'b0;
      pwm_q   <= '0;
      fs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      en_s1_q <= bus.dataEn;
      en_s2_q <= en_s1_q;
      en_dl_q <= en_s2_q;
      pre_q   <= tick ? '0 : pre_q + PW'(1);
      cnt_q   <= tick ? cnt_q + C_WIDTH'(1) : cnt_q;
      sel_q   <= sel_q ^ swap;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      inc_q   <= inc_d;
      pen_q   <= pen_d;
      pwm_q   <= pwm_d;
      fs_q    <= swap;
      err_q   <= is_cmd & bad;
    end
  end
  // host writes land in the bank that is shadow before this edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < OUT_NUM; i++) bank_q[b][i] <= '0;
    end else if (is_cmd & c_clr) begin
      for (int i = 0; i < OUT_NUM; i++) bank_q[~sel_q][i] <= '0;
    end else if (is_dat) begin
      bank_q[~sel_q][addr_q] <= bus.dataIn[C_WIDTH-1:0];
    end
  end
  assign bus.pwmOut      = pwm_q;
  assign bus.frameSync   = fs_q;
  assign bus.swapPending = pend_q;
  assign bus.cmdErr      = err_q;
endmodule

// File: tb/tb_plane_pwm_driver.sv
// tb_plane_pwm_driver: directed plan plus random host traffic against a behavioural model
module tb_plane_pwm_driver;
  localparam int N = 48, DW = 8, CW = 5, AW = 6, PR = 1, PER = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  plane_pwm_driver_if #(.OUT_NUM(N), .D_WIDTH(DW)) bus ();
  plane_pwm_driver #(.OUT_NUM(N), .D_WIDTH(DW), .C_WIDTH(CW), .A_WIDTH(AW), .PRESC(PR))
    dut (.clk(clk), .reset(reset), .bus(bus));
  int total = 0, bad = 0;
  int mb [2][N];
  int msel, maddr, minc, men, mpend, mn;
  logic h1, h2, h3;
  logic [N-1:0] xp;
  logic xfs, xerr;
  int fs_seen = 0, err_seen = 0;
  int dc [8];
  logic s_en, s_rs;
  logic [7:0] s_din;
  always @(posedge clk) begin
    s_en  <= bus.dataEn;
    s_rs  <= bus.rs;
    s_din <= bus.dataIn;
  end
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) mb[b][i] = 0;
    msel = 0; maddr = 0; minc = 0; men = 0; mpend = 0; mn = 0;
    h1 = 0; h2 = 0; h3 = 0; xp = '0; xfs = 0; xerr = 0;
  endtask
  // one clock edge: the transaction lands on the 3rd edge that samples the strobe low
  task automatic model_step();
    int cnt, sh, d;
    logic tick, swap;
    cnt  = (mn / PR) % PER;
    tick = (mn % PR) == PR - 1;
    for (int i = 0; i < N; i++) xp[i] = (men != 0) && (mb[msel][i] > cnt);
    swap = tick && cnt == PER - 1 && mpend != 0;
    xfs = swap; xerr = 0; sh = 1 - msel;
    if (swap) begin msel = sh; mpend = 0; end
    if (h2 == 1'b0 && h3 == 1'b1) begin
      d = int'(s_din);
      if (s_rs) begin
        if (d == 1) for (int i = 0; i < N; i++) mb[sh][i] = 0;
        else if (d == 2) maddr = 0;
        else if (d == 4 || d == 5) minc = d % 2;
        else if (d == 8 || d == 9) men = d % 2;
        else if (d == 16) mpend = 1;
        else if (d == 17) mpend = 0;
        else if (d >= 128 && (d - 128) < N) maddr = d - 128;
        else xerr = 1;
      end else begin
        mb[sh][maddr] = d % PER;
        maddr = minc != 0 ? (maddr + 1) % N : (maddr + N - 1) % N;
      end
    end
    h3 = h2; h2 = h1; h1 = s_en; mn++;
  endtask
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset) model_reset(); else model_step();
      check("pwmOut", 64'(bus.pwmOut), 64'(xp));
      check("frameSync", 64'(bus.frameSync), 64'(xfs));
      check("swapPending", 64'(bus.swapPending), 64'(mpend));
      check("cmdErr", 64'(bus.cmdErr), 64'(xerr));
      if (bus.frameSync) fs_seen++;
      if (bus.cmdErr) err_seen++;
    end
  end
  task automatic send_now(input logic r, input logic [7:0] v);
    bus.rs = r; bus.dataIn = v; bus.dataEn = 1'b0;
    repeat (4) @(negedge clk);
    #1 bus.dataEn = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic send(input logic r, input logic [7:0] v);
    @(negedge clk); #1;
    send_now(r, v);
  endtask
  task automatic wait_fs(input string nm);
    int k;
    k = 0;
    while (k < 200) begin
      @(negedge clk); #2;
      if (bus.frameSync) break;
      k++;
    end
    check(nm, 64'(k < 200), 64'(1));
  endtask
  task automatic count_period();
    for (int c = 0; c < 8; c++) dc[c] = 0;
    repeat (PER) begin
      @(negedge clk); #2;
      for (int c = 0; c < 8; c++) dc[c] += int'(bus.pwmOut[c]);
    end
  endtask
  task automatic wait_phase(input int ph);
    do begin @(negedge clk); #1; end while (mn % PER != ph);
  endtask
  initial begin
    int e0, k, r, sel_pick;
    logic [7:0] v;
    bus.dataIn = '0; bus.rs = 1'b0; bus.dataEn = 1'b1;
    repeat (3) @(negedge clk);
    #2 check("rst_pwm", 64'(bus.pwmOut), 64'(0));
    check("rst_pend", 64'(bus.swapPending), 64'(0));
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    send(1, 8'h05); send(1, 8'h02);
    send(0, 8'd31); send(0, 8'd16); send(0, 8'd0);
    check("t1_sh0", 64'(mb[1][0]), 64'(31));
    check("t1_sh1", 64'(mb[1][1]), 64'(16));
    check("t1_addr", 64'(maddr), 64'(3));
    check("t1_pwm", 64'(bus.pwmOut), 64'(0));
    send(1, 8'h09); send(1, 8'h10);
    wait_fs("t2_fs");
    count_period();
    check("t2_ch0", 64'(dc[0]), 64'(31));
    check("t2_ch1", 64'(dc[1]), 64'(16));
    check("t2_ch2", 64'(dc[2]), 64'(0));
    check("t2_pend", 64'(bus.swapPending), 64'(0));
    send(1, 8'h80); send(0, 8'd5);
    count_period();
    check("t3_hold", 64'(dc[0]), 64'(31));
    send(1, 8'h10);
    wait_fs("t3_fs");
    count_period();
    check("t3_ch0", 64'(dc[0]), 64'(5));
    check("t3_ch1", 64'(dc[1]), 64'(0));
    send(1, 8'h04); send(1, 8'h02); send(0, 8'd7);
    check("t4_wrap", 64'(maddr), 64'(N - 1));
    check("t4_sh0", 64'(mb[1 - msel][0]), 64'(7));
    e0 = err_seen;
    send(1, 8'hC0);
    check("t4_err", 64'(err_seen - e0), 64'(1));
    check("t4_addr", 64'(maddr), 64'(N - 1));
    wait_phase(2);
    send(1, 8'h84); send(1, 8'h10);
    wait_phase(29);
    e0 = fs_seen;
    send_now(0, 8'd20);
    check("t5_fs", 64'(fs_seen - e0), 64'(1));
    check("t5_act", 64'(mb[msel][4]), 64'(20));
    check("t5_shd", 64'(mb[1 - msel][4]), 64'(0));
    count_period();
    check("t5_ch4", 64'(dc[4]), 64'(20));
    check("t5_ch0", 64'(dc[0]), 64'(7));
    k = 0;
    while (k < 64 && !bus.pwmOut[0]) begin @(negedge clk); #2; k++; end
    check("t6_high", 64'(bus.pwmOut[0]), 64'(1));
    @(posedge clk); #2 reset = 1'b0;
    #1 check("t6_async", 64'(bus.pwmOut), 64'(0));
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    e0 = err_seen;
    send(1, 8'h03);
    check("t6_err", 64'(err_seen - e0), 64'(1));
    send(1, 8'h09); send(1, 8'h10);
    wait_fs("t6_fs");
    count_period();
    check("t6_clr", 64'(dc[0] + dc[4]), 64'(0));
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 2);
      sel_pick = $urandom_range(0, 11);
      v = 8'($urandom_range(0, 255));
      if (r == 0) begin
        case (sel_pick)
          0: v = 8'h01;  1: v = 8'h02;  2: v = 8'h04;  3: v = 8'h05;
          4: v = 8'h08;  5, 6: v = 8'h09;  7, 8: v = 8'h10;  9: v = 8'h11;
          10: v = 8'h80 | 8'($urandom_range(0, 63));
          default: ;
        endcase
        send(1, v);
      end else send(0, v);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
